branch_pred_ctrl: RTL and testbench
===================================

Name: branch_pred_ctrl

Overview:
- Gshare-style conditional-branch predictor and mispredict-recovery controller for the 5-stage MIPS pipeline.
- Predicts in D from a pattern history table (PHT) of 2-bit counters, indexed by PC XOR global history (GHR).
- Carries the prediction to E and compares it with the resolved outcome from the E-stage branch comparator (branch_takeE).
- Trains the PHT, repairs the speculative GHR and drives the flush/redirect controls on a mispredict.

Parameters:
- PHT_IDX_W, 6, PHT index width; the PHT has 2^PHT_IDX_W entries.
- GHR_W, 6, global history length; must be <= PHT_IDX_W.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- pcD  in  32  PC of the instruction in D
- branchD  in  1  D instruction is a conditional branch (beq/bne/bgtz/blez/bltz/bgez/bltzal/bgezal)
- stallD  in  1  D→E register holds
- flushE  in  1  external E bubble (hazard unit); not driven by a mispredict
- branch_takeE  in  1  resolved outcome from the branch comparator
- pred_takeD  out  1  predicted taken for the D instruction (combinational)
- pred_takeE  out  1  prediction carried with the E instruction
- mispredE  out  1  E branch resolved opposite to prediction (combinational)
- redirect_targetE  out  1  mispredE & branch_takeE: fetch from the branch target
- redirect_seqE  out  1  mispredE & ~branch_takeE: fetch from pcE+8
- ghr_specO  out  GHR_W  speculative GHR (debug/visibility)

Behaviour:
- Reset (async, rst=1):
  - every PHT entry = 2'b01 (weakly not-taken)
  - ghr_spec = ghr_commit = 0
  - E pipeline valid bit branch_vE = 0, so all E outputs = 0
  - pred_takeD is 0 after reset because the counters are 01
- Index: idxD = pcD[PHT_IDX_W+1:2] ^ {zero-extended ghr_spec}. Bits [1:0] are ignored.
- pred_takeD = branchD & PHT[idxD][1]. Zero latency, combinational.
- D→E register (captured when ~stallD): branch_vE, pred_takeE, idxE.
  - flushE or mispredE zeroes branch_vE.
  - When stallD=1 the register holds; a concurrent flushE still zeroes branch_vE.
- Resolution (E, combinational): mispredE = branch_vE & (pred_takeE != branch_takeE).
- Each cycle with branch_vE=1, on the clock edge:
  - PHT[idxE] saturating update: +1 if taken, capped at 11; -1 if not taken, floored at 00.
  - ghr_commit <= {ghr_commit[GHR_W-2:0], branch_takeE}.
- Speculative GHR:
  - branchD & ~stallD & ~mispredE: ghr_spec <= {ghr_spec[GHR_W-2:0], pred_takeD}.
  - mispredE: ghr_spec <= {ghr_commit[GHR_W-2:0], branch_takeE}. Recovery has priority over the D shift; the D instruction is on the wrong path and is flushed by the hazard unit.
- Same-index read/write collision: D reads the pre-update PHT value (no bypass). The bench must match this.
- Delay slot: the slot instruction is never flushed by this block. The redirect outputs only select the next fetch PC; the hazard unit flushes F/D younger than the slot.
- Correctly predicted branch: no redirect; only training occurs.
- Non-branch instructions in E: no PHT or GHR change.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight predictions are discarded.

Decomposition:
- Shared package/include holds:
  - 2-bit counter encodings SNT=00, WNT=01, WT=10, ST=11
  - PHT_RESET_VAL = WNT
  - default widths
- One sub-module, sat_counter2: the 2-bit saturating next-state function. It is instantiated for the update path only; the PHT storage stays a flop array in the top.

Test Plan:
1. Post-reset: pcD=0x00400010, branchD=1 → pred_takeD=0, ghr_specO=0. With E resolving branch_takeE=1 → mispredE=1, redirect_targetE=1, PHT entry becomes 10, ghr_specO=000001 next cycle.
2. Same branch resolved taken twice in a row with GHR forced constant (GHR_W=1 variant, history held) → counter 01→10→11; third prediction pred_takeD=1. Then three not-taken outcomes → 11→10→01→00, saturating at 00 on the fourth.
3. Predicted taken (counter 11) resolved not taken → mispredE=1, redirect_seqE=1, redirect_targetE=0. ghr_spec = {ghr_commit[4:0], 0}, overriding a concurrent branchD shift.
4. stallD=1 for 3 cycles while branchD=1 → ghr_spec unchanged; pred_takeE and idxE hold their value. On the release cycle exactly one shift occurs.
5. flushE=1 while a branch enters E → branch_vE=0: no PHT update, mispredE=0 despite opposite branch_takeE.
6. rst pulsed mid-stream after 5 trained branches → all 64 PHT entries read 01, both GHRs 0, E outputs 0 within the same cycle (async).

Source files
------------

// File: rtl/branch_pred_ctrl_pkg.sv
// Shared definitions for the gshare branch predictor.
//   ctr_e          : 2-bit saturating counter encodings
//   PHT_RESET_VAL  : value every PHT entry takes on reset (weakly not-taken)
//   *_DEF          : default index / history widths
package branch_pred_ctrl_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [1:0]  PHT_RESET_VAL = WNT;
  localparam int unsigned PHT_IDX_W_DEF = 6;
  localparam int unsigned GHR_W_DEF     = 6;

endpackage

// File: rtl/branch_pred_ctrl_sat_counter2.sv
// sat_counter2: next-state function of a 2-bit saturating counter.
//   i_cnt   : current counter value
//   i_taken : resolved branch outcome (1 = count up, 0 = count down)
//   o_cnt   : next counter value, clamped to SNT..ST
module sat_counter2
  import branch_pred_ctrl_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_taken) begin
      if (ctr_e'(i_cnt) != ST) o_cnt = i_cnt + 2'd1;
    end else begin
      if (ctr_e'(i_cnt) != SNT) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: gshare conditional-branch predictor and mispredict
// recovery for the 5-stage pipeline.
//   clk, rst          : clock, asynchronous active-high reset
//   pcD, branchD      : D-stage PC and "is conditional branch"
//   stallD            : D->E register holds
//   flushE            : external E bubble from the hazard unit
//   branch_takeE      : resolved outcome from the E-stage comparator
//   pred_takeD        : combinational prediction for the D instruction
//   pred_takeE        : prediction carried with the valid E branch
//   mispredE          : E branch resolved opposite to its prediction
//   redirect_targetE  : mispredicted, fetch from branch target
//   redirect_seqE     : mispredicted, fetch from pcE+8
//   ghr_specO         : speculative global history
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int unsigned PHT_IDX_W = PHT_IDX_W_DEF,
  parameter int unsigned GHR_W     = GHR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcD,
  input  logic             branchD,
  input  logic             stallD,
  input  logic             flushE,
  input  logic             branch_takeE,
  output logic             pred_takeD,
  output logic             pred_takeE,
  output logic             mispredE,
  output logic             redirect_targetE,
  output logic             redirect_seqE,
  output logic [GHR_W-1:0] ghr_specO
);

  localparam int unsigned PHT_N = 1 << PHT_IDX_W;

  logic [1:0]           r_pht [PHT_N];
  logic [GHR_W-1:0]     r_ghr_spec;
  logic [GHR_W-1:0]     r_ghr_commit;
  logic                 r_branch_vE;
  logic                 r_pred_takeE;
  logic [PHT_IDX_W-1:0] r_idxE;

  logic [PHT_IDX_W-1:0] w_ghr_ext;
  logic [PHT_IDX_W-1:0] w_idxD;
  logic                 w_pred_takeD;
  logic                 w_mispredE;
  logic [1:0]           w_cnt_next;
  // One spare MSB so the shift also works for GHR_W == 1.
  logic [GHR_W:0]       w_spec_shift;
  logic [GHR_W:0]       w_commit_shift;
  logic                 w_unused;

  always_comb begin
    w_ghr_ext             = '0;
    w_ghr_ext[GHR_W-1:0]  = r_ghr_spec;
  end

  assign w_idxD         = pcD[PHT_IDX_W+1:2] ^ w_ghr_ext;
  assign w_pred_takeD   = branchD & r_pht[w_idxD][1];
  assign w_mispredE     = r_branch_vE & (r_pred_takeE ^ branch_takeE);
  assign w_spec_shift   = {r_ghr_spec, w_pred_takeD};
  assign w_commit_shift = {r_ghr_commit, branch_takeE};
  assign w_unused       = ^{pcD[31:PHT_IDX_W+2], pcD[1:0],
                            w_spec_shift[GHR_W], w_commit_shift[GHR_W]};

  sat_counter2 u_sat (
    .i_cnt   (r_pht[r_idxE]),
    .i_taken (branch_takeE),
    .o_cnt   (w_cnt_next)
  );

  // No bypass: a D read of the entry being trained sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHT_N; i++) r_pht[i] <= PHT_RESET_VAL;
    end else if (r_branch_vE) begin
      r_pht[r_idxE] <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr_spec   <= '0;
      r_ghr_commit <= '0;
      r_branch_vE  <= 1'b0;
      r_pred_takeE <= 1'b0;
      r_idxE       <= '0;
    end else begin
      if (r_branch_vE) r_ghr_commit <= w_commit_shift[GHR_W-1:0];

      // Recovery rebuilds history from committed state plus the true
      // outcome; it wins over the wrong-path D shift.
      if (w_mispredE)             r_ghr_spec <= w_commit_shift[GHR_W-1:0];
      else if (branchD & ~stallD) r_ghr_spec <= w_spec_shift[GHR_W-1:0];

      if (~stallD) begin
        r_pred_takeE <= w_pred_takeD;
        r_idxE       <= w_idxD;
      end

      if (flushE | w_mispredE) r_branch_vE <= 1'b0;
      else if (~stallD)        r_branch_vE <= branchD;
    end
  end

  assign pred_takeD       = w_pred_takeD;
  assign pred_takeE       = r_branch_vE & r_pred_takeE;
  assign mispredE         = w_mispredE;
  assign redirect_targetE = w_mispredE & branch_takeE;
  assign redirect_seqE    = w_mispredE & ~branch_takeE;
  assign ghr_specO        = r_ghr_spec;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
module tb_branch_pred_ctrl;

  localparam int GMASK = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcD;
  logic        branchD, stallD, flushE, branch_takeE;
  logic        pred_takeD, pred_takeE, mispredE, redirect_targetE, redirect_seqE;
  logic [5:0]  ghr_specO;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_pht [64];
  int m_spec, m_commit, m_idxE;
  bit m_vE, m_predE;
  // expected values for the current cycle
  int e_idxD, e_ghr;
  bit e_predD, e_predE, e_mis, e_tgt, e_seq;

  branch_pred_ctrl #(.PHT_IDX_W(6), .GHR_W(6)) dut (
    .clk(clk), .rst(rst), .pcD(pcD), .branchD(branchD), .stallD(stallD),
    .flushE(flushE), .branch_takeE(branch_takeE), .pred_takeD(pred_takeD),
    .pred_takeE(pred_takeE), .mispredE(mispredE),
    .redirect_targetE(redirect_targetE), .redirect_seqE(redirect_seqE),
    .ghr_specO(ghr_specO)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc, input int g);
    return int'((pc >> 2) & 32'h3f) ^ g;
  endfunction

  function automatic logic [31:0] pc_for(input int entry);
    return 32'h0040_0000 | (32'((entry ^ m_spec) & GMASK) << 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_spec = 0; m_commit = 0; m_idxE = 0; m_vE = 0; m_predE = 0;
    e_predD = 0; e_mis = 0; e_idxD = 0;
  endtask

  task automatic drive(input logic [31:0] pc, input bit br, st, fl, tk);
    @(negedge clk);
    pcD = pc; branchD = br; stallD = st; flushE = fl; branch_takeE = tk;
    #1;
    e_idxD  = idx_of(pc, m_spec);
    e_predD = br && (m_pht[e_idxD] >= 2);
    e_predE = m_vE && m_predE;
    e_mis   = m_vE && (m_predE != tk);
    e_tgt   = e_mis && tk;
    e_seq   = e_mis && !tk;
    e_ghr   = m_spec;
  endtask

  task automatic tick();
    int nc;
    @(posedge clk);
    nc = m_commit;
    if (m_vE) begin
      if (branch_takeE) m_pht[m_idxE] = (m_pht[m_idxE] < 3) ? m_pht[m_idxE] + 1 : 3;
      else              m_pht[m_idxE] = (m_pht[m_idxE] > 0) ? m_pht[m_idxE] - 1 : 0;
      nc = ((m_commit << 1) | int'(branch_takeE)) & GMASK;
    end
    if (e_mis)                     m_spec = ((m_commit << 1) | int'(branch_takeE)) & GMASK;
    else if (branchD && !stallD)   m_spec = ((m_spec << 1) | int'(e_predD)) & GMASK;
    if (!stallD) begin m_predE = e_predD; m_idxE = e_idxD; end
    if (flushE || e_mis) m_vE = 0;
    else if (!stallD)    m_vE = branchD;
    m_commit = nc;
  endtask

  // issue a branch to a PHT entry, then resolve it in E with outcome tk
  task automatic train(input int entry, input bit tk);
    drive(pc_for(entry), 1, 0, 0, 0); tick();
    drive(32'h0, 0, 0, 0, tk); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; pcD = 32'h0040_00f0; branchD = 1; stallD = 0; flushE = 0; branch_takeE = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (pred_takeD !== 1'b0) begin n_err++; $display("FAIL reset_predD: got %0b want 0", pred_takeD); end
    n_vec++; if (pred_takeE !== 1'b0) begin n_err++; $display("FAIL reset_predE: got %0b want 0", pred_takeE); end
    n_vec++; if (mispredE !== 1'b0) begin n_err++; $display("FAIL reset_mispred: got %0b want 0", mispredE); end
    n_vec++; if (redirect_targetE !== 1'b0) begin n_err++; $display("FAIL reset_tgt: got %0b want 0", redirect_targetE); end
    n_vec++; if (ghr_specO !== 6'd0) begin n_err++; $display("FAIL reset_ghr: got %0d want 0", ghr_specO); end
    rst = 1'b0; branchD = 0;
    tick();
  endtask

  task automatic test_mispredict_taken();
    drive(32'h0040_0010, 1, 0, 0, 0);
    n_vec++; if (pred_takeD !== 1'b0) begin n_err++; $display("FAIL mt_predD: got %0b want 0", pred_takeD); end
    n_vec++; if (ghr_specO !== 6'd0) begin n_err++; $display("FAIL mt_ghr0: got %0d want 0", ghr_specO); end
    tick();
    drive(32'h0, 0, 0, 0, 1);
    n_vec++; if (mispredE !== 1'b1) begin n_err++; $display("FAIL mt_mispred: got %0b want 1", mispredE); end
    n_vec++; if (redirect_targetE !== 1'b1) begin n_err++; $display("FAIL mt_tgt: got %0b want 1", redirect_targetE); end
    n_vec++; if (redirect_seqE !== 1'b0) begin n_err++; $display("FAIL mt_seq: got %0b want 0", redirect_seqE); end
    tick();
    // entry 4 should now be WT; with ghr=1, pc index 5 maps back to entry 4
    drive(32'h0040_0014, 1, 0, 0, 0);
    n_vec++; if (ghr_specO !== 6'd1) begin n_err++; $display("FAIL mt_ghr1: got %0d want 1", ghr_specO); end
    n_vec++; if (pred_takeD !== 1'b1) begin n_err++; $display("FAIL mt_trained: got %0b want 1", pred_takeD); end
    tick();
    drive(32'h0, 0, 0, 0, 1);
    n_vec++; if ({mispredE, redirect_targetE, redirect_seqE} !== 3'b000) begin
      n_err++; $display("FAIL mt_correct: got %b want 000", {mispredE, redirect_targetE, redirect_seqE}); end
    tick();
  endtask

  task automatic test_saturation();
    bit ep [10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    bit ot [10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 10; i++) begin
      drive(pc_for(20), 1, 0, 0, 0);
      n_vec++; if (pred_takeD !== ep[i]) begin n_err++; $display("FAIL sat_pred[%0d]: got %0b want %0b", i, pred_takeD, ep[i]); end
      tick();
      drive(32'h0, 0, 0, 0, ot[i]);
      n_vec++; if (mispredE !== (ep[i] ^ ot[i])) begin n_err++; $display("FAIL sat_mis[%0d]: got %0b want %0b", i, mispredE, ep[i] ^ ot[i]); end
      tick();
    end
  endtask

  task automatic test_mispredict_seq();
    int c;
    train(33, 1); train(33, 1);
    drive(pc_for(33), 1, 0, 0, 0);
    n_vec++; if (pred_takeD !== 1'b1) begin n_err++; $display("FAIL ms_predD: got %0b want 1", pred_takeD); end
    tick();
    drive(32'h0040_0abc, 1, 0, 0, 0);
    n_vec++; if ({mispredE, redirect_seqE, redirect_targetE} !== 3'b110) begin
      n_err++; $display("FAIL ms_redirect: got %b want 110", {mispredE, redirect_seqE, redirect_targetE}); end
    c = m_commit;
    tick();
    drive(32'h0, 0, 0, 0, 0);
    n_vec++; if (ghr_specO !== 6'((c << 1) & GMASK)) begin n_err++; $display("FAIL ms_ghr: got %0d want %0d", ghr_specO, (c << 1) & GMASK); end
    n_vec++; if (pred_takeE !== 1'b0) begin n_err++; $display("FAIL ms_wrongpath: got %0b want 0", pred_takeE); end
    tick();
  endtask

  task automatic test_stall();
    int g0;
    bit p;
    train(40, 1); train(40, 1);
    drive(pc_for(40), 1, 0, 0, 1); tick();
    g0 = m_spec;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0040_0000 | 32'($urandom_range(0, 255) << 2), 1, 1, 0, 1);
      n_vec++; if (ghr_specO !== 6'(g0)) begin n_err++; $display("FAIL st_ghr[%0d]: got %0d want %0d", i, ghr_specO, g0); end
      n_vec++; if (pred_takeE !== 1'b1) begin n_err++; $display("FAIL st_predE[%0d]: got %0b want 1", i, pred_takeE); end
      tick();
    end
    drive(pc_for(40), 1, 0, 0, 1);
    p = e_predD;
    tick();
    drive(32'h0, 0, 0, 0, p);
    n_vec++; if (ghr_specO !== 6'(((g0 << 1) | int'(p)) & GMASK)) begin
      n_err++; $display("FAIL st_release: got %0d want %0d", ghr_specO, ((g0 << 1) | int'(p)) & GMASK); end
    tick();
  endtask

  task automatic test_flush();
    drive(pc_for(50), 1, 0, 1, 0); tick();
    drive(32'h0, 0, 0, 0, 1);
    n_vec++; if ({mispredE, pred_takeE, redirect_targetE} !== 3'b000) begin
      n_err++; $display("FAIL fl_outs: got %b want 000", {mispredE, pred_takeE, redirect_targetE}); end
    tick();
    drive(pc_for(50), 1, 0, 0, 0);
    n_vec++; if (pred_takeD !== 1'b0) begin n_err++; $display("FAIL fl_noupdate: got %0b want 0", pred_takeD); end
    tick();
    drive(32'h0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 8), $urandom_range(0, 1) == 1);
      n_vec++; if (pred_takeD !== e_predD) begin n_err++; $display("FAIL rnd_predD[%0d]: got %0b want %0b", i, pred_takeD, e_predD); end
      n_vec++; if (pred_takeE !== e_predE) begin n_err++; $display("FAIL rnd_predE[%0d]: got %0b want %0b", i, pred_takeE, e_predE); end
      n_vec++; if (mispredE !== e_mis) begin n_err++; $display("FAIL rnd_mis[%0d]: got %0b want %0b", i, mispredE, e_mis); end
      n_vec++; if (redirect_targetE !== e_tgt) begin n_err++; $display("FAIL rnd_tgt[%0d]: got %0b want %0b", i, redirect_targetE, e_tgt); end
      n_vec++; if (redirect_seqE !== e_seq) begin n_err++; $display("FAIL rnd_seq[%0d]: got %0b want %0b", i, redirect_seqE, e_seq); end
      n_vec++; if (ghr_specO !== 6'(e_ghr)) begin n_err++; $display("FAIL rnd_ghr[%0d]: got %0d want %0d", i, ghr_specO, e_ghr); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) train(60, 1);
    drive(pc_for(60), 1, 0, 0, 1); tick();
    drive(pc_for(60), 1, 0, 0, 0);
    n_vec++; if ({pred_takeD, pred_takeE, mispredE} !== 3'b111) begin
      n_err++; $display("FAIL ar_before: got %b want 111", {pred_takeD, pred_takeE, mispredE}); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if ({pred_takeD, pred_takeE, mispredE, redirect_targetE, redirect_seqE} !== 5'b0) begin
      n_err++; $display("FAIL ar_outs: got %b want 00000", {pred_takeD, pred_takeE, mispredE, redirect_targetE, redirect_seqE}); end
    n_vec++; if (ghr_specO !== 6'd0) begin n_err++; $display("FAIL ar_ghr: got %0d want 0", ghr_specO); end
    model_reset();
    @(negedge clk);
    rst = 1'b0; branchD = 0; stallD = 0; flushE = 0;
    tick();
    for (int x = 0; x < 64; x++) begin
      drive(pc_for(x), 1, 0, 0, 0);
      n_vec++; if (pred_takeD !== 1'b0) begin n_err++; $display("FAIL ar_pht[%0d]: got %0b want 0", x, pred_takeD); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mispredict_taken();
    test_saturation();
    test_mispredict_seq();
    test_stall();
    test_flush();
    test_random(400);
    test_async_reset();
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
